// File: rtl/prll_bs_rr_arbiter_nd.sv
// prll_bs_rr_arbiter_nd
//   This is a shared parallel bus that joins `drvrs` driver FIFOs. A registered
//   round-robin arbiter picks one pending driver and pops one word from it.
//   It then pushes that word to the destination driver, or to all drivers
//   except the source when the word is a broadcast. The destination id is
//   taken from the word header.
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   synchronous, active-low reset
//     pndng     in   [drvrs]        driver k FIFO non-empty (first-word fall-through)
//     D_pop     in   [drvrs*bits]   lane k = head word of driver k
//     pop       out  [drvrs]        one-hot pulse that consumes the head word of driver k
//     push      out  [drvrs]        write strobe into the receive FIFO of driver k
//     D_push    out  [drvrs*bits]   captured word, replicated on every lane
//     busy      out                 high in GRANT or DELIVER
//     pkt_cnt   out  [32]           delivered packets      (PRLL_BS_ARB_CNT_EN only)
//     drop_cnt  out  [16]           dropped packets        (PRLL_BS_ARB_CNT_EN only)
//
//   Optional feature: define PRLL_BS_ARB_CNT_EN to get the packet/drop counters.
module prll_bs_rr_arbiter_nd #(
  parameter int unsigned bits    = 256,
  parameter int unsigned drvrs   = 4,
  parameter int unsigned id_bits = 8,
  parameter logic [id_bits-1:0] broadcast = {id_bits{1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [drvrs-1:0]        pndng,
  input  logic [drvrs*bits-1:0]   D_pop,
  output logic [drvrs-1:0]        pop,
  output logic [drvrs-1:0]        push,
  output logic [drvrs*bits-1:0]   D_push,
  output logic                    busy
`ifdef PRLL_BS_ARB_CNT_EN
  ,
  output logic [31:0]             pkt_cnt,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int unsigned GW = $clog2(drvrs);
  localparam logic [id_bits-1:0] DRVRS_ID = id_bits'(drvrs);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] DELIVER = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [bits-1:0]    pkt_q, pkt_d;

  logic               any_req;
  logic [GW-1:0]      winner;
  logic [GW-1:0]      cand;
  logic [id_bits-1:0] id;
  logic [drvrs-1:0]   deliver_mask;

  // (p + off) mod drvrs without a general divider; off < drvrs always.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= drvrs) s = s - drvrs;
    return GW'(s);
  endfunction

  // Priority scan that starts at rr_ptr and wraps around.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      cand = wrap_add(rr_ptr_q, i);
      if (!any_req && pndng[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Decode the destination id from the captured header.
  always_comb begin
    id           = pkt_q[bits-1 -: id_bits];
    deliver_mask = '0;
    if (id < DRVRS_ID) begin
      for (int unsigned k = 0; k < drvrs; k++) begin
        if (id == id_bits'(k)) deliver_mask[k] = 1'b1;
      end
    end else if (id == broadcast) begin
      deliver_mask        = '1;
      deliver_mask[gnt_q] = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    pkt_d    = pkt_q;
    case (state_q)
      IDLE, DELIVER: begin
        if (any_req) begin
          state_d  = GRANT;
          gnt_d    = winner;
          rr_ptr_d = wrap_add(winner, 1);
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        for (int unsigned k = 0; k < drvrs; k++) begin
          if (gnt_q == GW'(k)) pkt_d = D_pop[k*bits +: bits];
        end
        state_d = DELIVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < drvrs; k++) begin
      pop[k] = (state_q == GRANT) && (gnt_q == GW'(k));
    end
  end

  assign push   = (state_q == DELIVER) ? deliver_mask : '0;
  // pkt_q only changes at the end of GRANT, so D_push holds outside DELIVER.
  assign D_push = {drvrs{pkt_q}};
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      pkt_q    <= pkt_d;
    end
  end

`ifdef PRLL_BS_ARB_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == DELIVER) begin
      if (deliver_mask != '0) pkt_cnt_d  = pkt_cnt_q + 32'd1;
      else                    drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_prll_bs_rr_arbiter_nd.sv
// tb_prll_bs_rr_arbiter_nd
//   Directed bench for prll_bs_rr_arbiter_nd (drvrs=4, bits=256, id_bits=8).
//   Counter checks are active when PRLL_BS_ARB_CNT_EN is defined.
module tb_prll_bs_rr_arbiter_nd;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    pndng;
  logic [1023:0] D_pop;
  logic [3:0]    pop;
  logic [3:0]    push;
  logic [1023:0] D_push;
  logic          busy;
`ifdef PRLL_BS_ARB_CNT_EN
  logic [31:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
`endif

  logic [255:0]  lane [4];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  always_comb D_pop = {lane[3], lane[2], lane[1], lane[0]};

  prll_bs_rr_arbiter_nd #(
    .bits      (256),
    .drvrs     (4),
    .id_bits   (8),
    .broadcast (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy)
`ifdef PRLL_BS_ARB_CNT_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [7:0] id, input logic [7:0] fill);
    return {id, {31{fill}}};
  endfunction

  initial begin
    logic [3:0] exp_pop [5];
    exp_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b0;
    pndng = 4'b0000;
    for (int k = 0; k < 4; k++) lane[k] = '0;
    step();
    step();

    // Reset state
    check("rst_pop",  pop,  4'b0000);
    check("rst_push", push, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_dpush_l0", D_push[255:0],    256'd0);
    check("rst_dpush_l3", D_push[1023:768], 256'd0);
`ifdef PRLL_BS_ARB_CNT_EN
    check("rst_pkt_cnt",  pkt_cnt,  32'd0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
`endif
    reset = 1'b1;

    // Round-robin under continuous demand, all ids 0x00
    for (int k = 0; k < 4; k++) lane[k] = mk(8'h00, 8'h10 + 8'(k));
    pndng = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_pop", pop, exp_pop[i]);
      check("rr_grant_push0", push, 4'b0000);
      if (i == 4) pndng = 4'b0000;
      step();
      check("rr_push", push, 4'b0001);
      check("rr_deliver_pop0", pop, 4'b0000);
      check("rr_dpush_l2", D_push[767:512], mk(8'h00, 8'h10 + 8'(i % 4)));
    end
    step();
    check("rr_idle_busy", busy, 1'b0);
    check("rr_idle_push", push, 4'b0000);
`ifdef PRLL_BS_ARB_CNT_EN
    check("rr_pkt_cnt", pkt_cnt, 32'd5);
`endif

    // Unicast: driver 2 -> id 0x01
    lane[2] = mk(8'h01, 8'hA5);
    pndng = 4'b0100;
    step();
    check("uni_pop",  pop,  4'b0100);
    check("uni_busy", busy, 1'b1);
    check("uni_push_early", push, 4'b0000);
    pndng = 4'b0000;
    step();
    check("uni_push", push, 4'b0010);
    check("uni_dpush_l1", D_push[511:256], mk(8'h01, 8'hA5));
    check("uni_dpush_l0", D_push[255:0],   mk(8'h01, 8'hA5));
    step();
    check("uni_push_after", push, 4'b0000);
    check("uni_busy_after", busy, 1'b0);
    check("uni_dpush_hold", D_push[511:256], mk(8'h01, 8'hA5));
`ifdef PRLL_BS_ARB_CNT_EN
    check("uni_pkt_cnt", pkt_cnt, 32'd6);
`endif

    // Broadcast from driver 1
    lane[1] = mk(8'hFF, 8'h3C);
    pndng = 4'b0010;
    step();
    check("bc_pop", pop, 4'b0010);
    pndng = 4'b0000;
    step();
    check("bc_push", push, 4'b1101);
    step();
    check("bc_push_after", push, 4'b0000);
`ifdef PRLL_BS_ARB_CNT_EN
    check("bc_pkt_cnt", pkt_cnt, 32'd7);
`endif

    // Invalid id from driver 3 is dropped
    lane[3] = mk(8'h07, 8'h5A);
    pndng = 4'b1000;
    step();
    check("drop_pop", pop, 4'b1000);
    pndng = 4'b0000;
    step();
    check("drop_push", push, 4'b0000);
    check("drop_busy", busy, 1'b1);
    step();
`ifdef PRLL_BS_ARB_CNT_EN
    check("drop_drop_cnt", drop_cnt, 16'd1);
    check("drop_pkt_cnt",  pkt_cnt,  32'd7);
`endif

    // Reset asserted during GRANT (driver 2 granted, rr_ptr then 3)
    lane[0] = mk(8'h00, 8'hE7);
    pndng = 4'b0100;
    step();
    check("mrst_pop_grant", pop, 4'b0100);
    reset = 1'b0;
    step();
    check("mrst_pop",  pop,  4'b0000);
    check("mrst_push", push, 4'b0000);
    check("mrst_busy", busy, 1'b0);
`ifdef PRLL_BS_ARB_CNT_EN
    check("mrst_pkt_cnt",  pkt_cnt,  32'd0);
    check("mrst_drop_cnt", drop_cnt, 16'd0);
`endif
    reset = 1'b1;
    pndng = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_no_push", push, 4'b0000);
    end
    // rr_ptr must be back at 0: driver 0 wins over 1..3
    pndng = 4'b1111;
    step();
    check("mrst_rr_pop", pop, 4'b0001);
    pndng = 4'b0000;

    // Self-address delivery, then idle
    step();
    check("self_push", push, 4'b0001);
    check("self_dpush_l0", D_push[255:0], mk(8'h00, 8'hE7));
    step();
    check("self_busy_after", busy, 1'b0);
    check("self_push_after", push, 4'b0000);
`ifdef PRLL_BS_ARB_CNT_EN
    check("self_pkt_cnt", pkt_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
